// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALUOp codes, execute-stage states and datapath width
package alu_pkg;

   localparam int XLEN = 32;

   // ALUOp codes as produced by the control decoder; codes 1010-1111 execute as add
   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_AND  = 4'b0010,
      OP_OR   = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_SLL  = 4'b0101,
      OP_SRL  = 4'b0110,
      OP_SRA  = 4'b0111,
      OP_SLT  = 4'b1000,
      OP_SLTU = 4'b1001
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } exec_state_t;

endpackage

// File: rtl/alu_seq_shifter.sv
// rtl/alu_seq_shifter.sv - iterative one-bit-per-cycle shifter with down-counter
module alu_seq_shifter #(
   parameter int XLEN = 32,
   parameter int SHW  = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            step,
   input  logic [XLEN-1:0] load_value,
   input  logic [SHW-1:0]  load_amt,
   input  logic            dir_left,
   input  logic            arith,
   output logic [XLEN-1:0] step_value,
   output logic            done
);

   logic [XLEN-1:0] value_q;
   logic [SHW-1:0]  count_q;
   logic            left_q;
   logic            arith_q;

   // One-bit shift of the current value; right shifts fill with the MSB only for sra
   always_comb begin
      step_value = {value_q[XLEN-2:0], 1'b0};
      if (!left_q) begin
         step_value = {arith_q & value_q[XLEN-1], value_q[XLEN-1:1]};
      end
   end

   // done means the pending step is the last one, so the owner can latch step_value
   assign done = (count_q == SHW'(1));

   // Load operand/amount/mode on accept, then shift and count down once per step
   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= '0;
         count_q <= '0;
         left_q  <= 1'b0;
         arith_q <= 1'b0;
      end else if (load) begin
         value_q <= load_value;
         count_q <= load_amt;
         left_q  <= dir_left;
         arith_q <= arith;
      end else if (step && (count_q != '0)) begin
         value_q <= step_value;
         count_q <= count_q - SHW'(1);
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with valid/ready handshakes and iterative shifts
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int XLEN = alu_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_op,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   localparam int SHW = $clog2(XLEN);

   exec_state_t     state_q;
   exec_state_t     state_d;
   logic            accept;
   logic            is_shift;
   logic            sh_load;
   logic            sh_step;
   logic            sh_done;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] alu_value;
   logic [XLEN-1:0] imm_value;
   logic [XLEN-1:0] sh_value;
   logic [XLEN-1:0] result_q;
   logic            zero_q;

   assign in_ready  = (state_q == IDLE) && !rst;
   assign accept    = in_valid && in_ready;
   assign shamt     = operand_b[SHW-1:0];
   assign is_shift  = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign zero      = zero_q;

   // Single-cycle ALU; add is the fallback for shifts (handled elsewhere) and undefined codes
   always_comb begin
      alu_value = operand_a + operand_b;
      case (alu_op)
         OP_SUB:  alu_value = operand_a - operand_b;
         OP_AND:  alu_value = operand_a & operand_b;
         OP_OR:   alu_value = operand_a | operand_b;
         OP_XOR:  alu_value = operand_a ^ operand_b;
         OP_SLT:  alu_value = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
         OP_SLTU: alu_value = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
         default: alu_value = operand_a + operand_b;
      endcase
      imm_value = is_shift ? operand_a : alu_value;
   end

   alu_seq_shifter #(
      .XLEN (XLEN),
      .SHW  (SHW)
   ) u_shifter (
      .clk        (clk),
      .rst        (rst),
      .load       (sh_load),
      .step       (sh_step),
      .load_value (operand_a),
      .load_amt   (shamt),
      .dir_left   (alu_op == OP_SLL),
      .arith      (alu_op == OP_SRA),
      .step_value (sh_value),
      .done       (sh_done)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and shifter control; a zero shift amount skips SHIFT entirely
   always_comb begin
      state_d = state_q;
      sh_load = 1'b0;
      sh_step = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_shift) begin
                  sh_load = 1'b1;
                  state_d = (shamt == '0) ? DONE : SHIFT;
               end else begin
                  state_d = DONE;
               end
            end
         end
         SHIFT: begin
            sh_step = 1'b1;
            if (sh_done) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Result/zero register: written at accept for one-cycle ops, on the last shift step otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         zero_q   <= 1'b0;
      end else if (accept && !(is_shift && (shamt != '0))) begin
         result_q <= imm_value;
         zero_q   <= (imm_value == '0);
      end else if ((state_q == SHIFT) && sh_done) begin
         result_q <= sh_value;
         zero_q   <= (sh_value == '0);
      end
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage consumer of the 4-bit ALUOp code that the control decoder produces. It is the receiving end of the decode→execute control interface.
- Accepts one operation per valid/ready handshake and computes the result.
- Logic/arith/compare ops complete in one cycle. Shifts run on an iterative one-bit-per-cycle shifter.
- Drives result and zero (used for branch compare) back to the datapath over an output valid/ready handshake.

Parameters:
- XLEN, 32, operand/result width.
- SHW, $clog2(XLEN), shift-amount width (derived, not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit can accept an operation.
- alu_op  input  4  ALUOp code: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sll, 0110 srl, 0111 sra, 1000 slt, 1001 sltu.
- operand_a  input  XLEN  rs1 value.
- operand_b  input  XLEN  rs2 value or immediate.
- out_valid  output  1  result available.
- out_ready  input  1  downstream consumes the result.
- result  output  XLEN  computed value.
- zero  output  1  result == 0.

Behaviour:
- Clocking and reset: one clock (clk); rst is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, result=0, zero=0, shift counter=0. in_ready=0 while rst is high.
- in_ready = (state==IDLE) && !rst. It is combinational from state only, never from in_valid.
- Accept: in_valid && in_ready at a rising edge. operand_a, operand_b and alu_op are captured internally; inputs are don't-care afterwards.
- States: IDLE, SHIFT, DONE.
- IDLE, non-shift op accepted: result is computed from the inputs at the accept edge and registered; go to DONE. out_valid rises the cycle after accept (latency 1).
- IDLE, shift op (0101/0110/0111) accepted: load shift register = operand_a and counter = operand_b[SHW-1:0].
  - counter==0: go directly to DONE with result=operand_a (latency 1).
  - otherwise: go to SHIFT.
- SHIFT: each cycle shift one bit and decrement the counter.
  - sll fills with 0; srl fills with 0; sra fills with the current MSB.
  - When the counter reaches 0 on the edge performing the last shift, go to DONE.
  - Total latency for shamt k>0 is k+1 cycles from accept to out_valid.
- Only operand_b[SHW-1:0] is used as the shift amount; upper bits are ignored (e.g. b=33 shifts by 1).
- DONE: out_valid=1; result and zero are held stable until out_valid && out_ready. Then go to IDLE.
  - No accept in the same cycle, because in_ready is low in DONE. Maximum throughput is one op per 2 cycles.
- Arithmetic is modulo 2^XLEN; overflow and carry are dropped.
- slt: signed compare; sltu: unsigned compare. Both produce {XLEN-1 zeros, cmp bit}.
- Codes 1010–1111: treated as add (matches the decoder default).
- zero = (result==0) for every op, registered alongside result.
- Backpressure: out_ready low in DONE holds the state indefinitely. in_valid seen during SHIFT/DONE is ignored; the upstream source must hold it.
- Reset mid-operation (SHIFT or DONE): the operation is aborted and no output is produced. The next cycle after rst deasserts, the unit is IDLE with in_ready=1.
- out_ready high while out_valid is low has no effect.

Decomposition:
- Shared package alu_pkg:
  - typedef alu_op_t (4-bit enum, the ten codes above). The control decoder is to adopt the same enum.
  - typedef exec_state_t {IDLE, SHIFT, DONE}.
  - localparam XLEN.
- One sub-module: alu_seq_shifter, holding the shift register, counter, direction/arith select, load/step inputs and a done flag.
- The single-cycle combinational ALU stays inline in alu_exec_unit.

Test Plan:
- Reset and simple op: rst for 2 cycles, then add a=5, b=7 → in_ready=1 after reset; out_valid the cycle after accept; result=12, zero=0.
- Subtract and zero flag: sub a=0x10, b=0x10 → result=0, zero=1. Also sub a=0, b=1 → result=0xFFFFFFFF, zero=0.
- Iterative shifts with latency check:
  - sra a=0x80000000, b=4 → result=0xF8000000, out_valid exactly 5 cycles after accept.
  - sll a=1, b=31 → 0x80000000 at 32 cycles.
  - srl b=0 → result=a at 1 cycle.
  - sll a=1, b=33 → 0x2.
- Compare ops: slt a=0xFFFFFFFF, b=1 → 1; sltu with the same operands → 0. Undefined code 1100 with a=3, b=4 → 7.
- Backpressure and handshake: hold out_ready=0 for 5 cycles in DONE → result stable, in_ready=0, a second in_valid is not accepted. Raise out_ready → IDLE next cycle, then the second op is accepted.
- Reset mid-shift: sll b=20, assert rst at the 6th SHIFT cycle → out_valid never rises; IDLE with in_ready=1 the cycle after rst deasserts; result=0.
